muldiv_ctrl: RTL and testbench

//  Sequencer for the multiply/divide resource and the 64-bit HI/LO register in the pipelined CPU.

---
 rtl/muldiv_pkg.sv | 48 ++++
 rtl/muldiv_lat_counter.sv | 36 +++
 rtl/muldiv_ctrl.sv | 148 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared constants for the HI/LO multiply/divide sequencer:
//                EX op encodings, FSM state encoding and latency-counter
//                width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    // EX-stage op encodings (7 is reserved and treated as no-op)
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam int DEF_MUL_CYCLES = 4;
    localparam int DEF_DIV_CYCLES = 32;

    // Counter width able to hold (max latency - 1); never narrower than 1 bit
    function automatic int lat_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    localparam int LAT_W = lat_width(DEF_MUL_CYCLES, DEF_DIV_CYCLES);

    // Ops that occupy the arithmetic unit
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // Ops that the sequencer accepts at all
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_lat_counter
//  Description : Loadable down-counter with zero flag, used to time the
//                fixed latency of the multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_lat_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Clear has priority over load, load over decrement; saturates at zero
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : Sequencer for the multi-cycle multiply/divide unit and the
//                64-bit HI/LO register. Accepts ops from EX, times the unit
//                latency, issues a one-cycle HI/LO write and stalls the
//                pipeline against hazards on the in-flight result.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid_i,
    input  logic [2:0]  ex_op_i,
    input  logic [31:0] ex_rs_i,
    input  logic [31:0] ex_rt_i,
    input  logic        mf_req_i,
    input  logic        flush_i,
    input  logic [63:0] hilo_cur_i,
    input  logic [63:0] unit_result_i,
    output logic        unit_start_o,
    output logic        unit_div_o,
    output logic        unit_signed_o,
    output logic [31:0] unit_a_o,
    output logic [31:0] unit_b_o,
    output logic        unit_abort_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [63:0] hilo_wdata_o,
    output logic        div_zero_o
);
    import muldiv_pkg::*;

    localparam int               CNT_W    = lat_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q;
    logic [31:0]      a_q, b_q;
    logic             div_q, signed_q, start_q, abort_q;

    logic             ex_op_req, accept, is_div_op;
    logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    assign ex_op_req = ex_valid_i && op_is_valid(ex_op_i);
    // A flush on the accept edge drops the op entirely
    assign accept    = ex_op_req && (state_q == ST_IDLE) && !flush_i;
    assign is_div_op = (ex_op_i == OP_DIV) || (ex_op_i == OP_DIVU);

    assign cnt_load     = accept && op_is_arith(ex_op_i);
    assign cnt_load_val = is_div_op ? DIV_LOAD : MUL_LOAD;
    assign cnt_dec      = (state_q == ST_RUN);
    assign cnt_clr      = (state_q == ST_RUN) && flush_i;

    muldiv_lat_counter #(
        .WIDTH(CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state logic: flush cancels RUN but never an already-committed WRITE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = op_is_arith(ex_op_i) ? ST_RUN : ST_WRITE;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, operand latches, one-cycle start/abort pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NONE;
            a_q      <= '0;
            b_q      <= '0;
            div_q    <= 1'b0;
            signed_q <= 1'b0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= accept && op_is_arith(ex_op_i);
            abort_q <= (state_q == ST_RUN) && flush_i;
            if (accept) begin
                op_q     <= ex_op_i;
                a_q      <= ex_rs_i;
                b_q      <= ex_rt_i;
                div_q    <= is_div_op;
                signed_q <= (ex_op_i == OP_MULT) || (ex_op_i == OP_DIV);
            end else if (state_d == ST_IDLE) begin
                // unit mode flags are only meaningful while an op is in flight
                div_q    <= 1'b0;
                signed_q <= 1'b0;
            end
        end
    end

    // HI/LO write data: packed {LO, HI}; zero outside the write cycle
    always_comb begin
        hilo_wdata_o = '0;
        if (state_q == ST_WRITE) begin
            case (op_q)
                OP_MTHI: hilo_wdata_o = {hilo_cur_i[63:32], a_q};
                OP_MTLO: hilo_wdata_o = {a_q, hilo_cur_i[31:0]};
                default: hilo_wdata_o = unit_result_i;
            endcase
        end
    end

    assign unit_start_o  = start_q;
    assign unit_div_o    = div_q;
    assign unit_signed_o = signed_q;
    assign unit_a_o      = a_q;
    assign unit_b_o      = b_q;
    assign unit_abort_o  = abort_q;
    assign busy_o        = (state_q != ST_IDLE);
    // WRITE is busy so a following MFHI/MFLO sees the updated register
    assign stall_o       = busy_o && (ex_op_req || mf_req_i);
    assign hilo_we_o     = (state_q == ST_WRITE);
    assign div_zero_o    = hilo_we_o && div_q && (b_q == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_ctrl
//  Description : Self-checking bench for muldiv_ctrl: vector table, directed
//                corner-case sequences and a randomized run checked every
//                cycle against a timestamp-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_op = 3'd0;
    logic [31:0] ex_rs = '0, ex_rt = '0;
    logic        mf_req = 1'b0, flush = 1'b0;
    logic [63:0] hilo_cur = '0, unit_result = '0;
    logic        unit_start, unit_div, unit_signed, unit_abort, busy, stall, hilo_we, div_zero;
    logic [31:0] unit_a, unit_b;
    logic [63:0] hilo_wdata;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    muldiv_ctrl #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid_i    (ex_valid),
        .ex_op_i       (ex_op),
        .ex_rs_i       (ex_rs),
        .ex_rt_i       (ex_rt),
        .mf_req_i      (mf_req),
        .flush_i       (flush),
        .hilo_cur_i    (hilo_cur),
        .unit_result_i (unit_result),
        .unit_start_o  (unit_start),
        .unit_div_o    (unit_div),
        .unit_signed_o (unit_signed),
        .unit_a_o      (unit_a),
        .unit_b_o      (unit_b),
        .unit_abort_o  (unit_abort),
        .busy_o        (busy),
        .stall_o       (stall),
        .hilo_we_o     (hilo_we),
        .hilo_wdata_o  (hilo_wdata),
        .div_zero_o    (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (fails so far %0d)", fails);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: tracks the in-flight op by cycle timestamps.
    // An op accepted at the end of cycle c has its start pulse in c+1 and
    // its HI/LO write in c+1+latency (latency 0 for MTHI/MTLO).
    // ------------------------------------------------------------------
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_acc = -10, m_wr = -10, m_abort = -10;
    logic [2:0]  m_op = 3'd0;
    logic [31:0] m_a = '0, m_b = '0;

    function automatic bit is_mul(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2);
    endfunction
    function automatic bit is_dv(input logic [2:0] op);
        return (op == 3'd3) || (op == 3'd4);
    endfunction

    always @(negedge clk) begin
        logic [135:0] dut_v, exp_v;
        logic         e_we, e_div, e_sgn, e_dz, req;
        logic [63:0]  e_wd;
        req   = ex_valid && (ex_op >= 3'd1) && (ex_op <= 3'd6);
        e_we  = m_active && (cyc == m_wr);
        e_div = m_active && is_dv(m_op);
        e_sgn = m_active && ((m_op == 3'd1) || (m_op == 3'd3));
        if (!e_we)            e_wd = '0;
        else if (m_op == 3'd5) e_wd = {hilo_cur[63:32], m_a};
        else if (m_op == 3'd6) e_wd = {m_a, hilo_cur[31:0]};
        else                   e_wd = unit_result;
        e_dz  = e_we && is_dv(m_op) && (m_b == 32'd0);
        exp_v = {m_active && (is_mul(m_op) || is_dv(m_op)) && (cyc == m_acc + 1),
                 e_div, e_sgn, m_a, m_b, (cyc == m_abort), m_active,
                 m_active && (req || mf_req), e_we, e_wd, e_dz};
        dut_v = {unit_start, unit_div, unit_signed, unit_a, unit_b, unit_abort, busy,
                 stall, hilo_we, hilo_wdata, div_zero};
        if (mon_en) begin
            tests++;
            if (dut_v !== exp_v) begin
                fails++;
                $display("FAIL model cyc=%0d got=%h expected=%h", cyc, dut_v, exp_v);
            end
        end
        // advance the model across the coming clock edge
        if (reset) begin
            m_active = 1'b0;
            m_a = '0;
            m_b = '0;
            m_abort = -10;
        end else if (m_active && flush && (cyc != m_wr)) begin
            m_active = 1'b0;
            m_abort = cyc + 1;
        end else if (m_active && (cyc == m_wr)) begin
            m_active = 1'b0;
        end else if (!m_active && req && !flush) begin
            m_active = 1'b1;
            m_op  = ex_op;
            m_a   = ex_rs;
            m_b   = ex_rt;
            m_acc = cyc;
            m_wr  = cyc + 1 + (is_dv(ex_op) ? DIV_LAT : (is_mul(ex_op) ? MUL_LAT : 0));
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            next();
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Vector table: one op from IDLE, expected unit setup, latency, data
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt;
        logic [63:0] hcur, ures;
        int          lat;
        logic        start, dv, sgn, dz;
        logic [63:0] wd;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int idx);
        vec_t v;
        int   k;
        v = vecs[idx];
        next();
        ex_valid = 1'b1; ex_op = v.op; ex_rs = v.rs; ex_rt = v.rt;
        hilo_cur = v.hcur; unit_result = v.ures;
        next();
        ex_valid = 1'b0; ex_op = 3'd0;
        @(negedge clk);
        chk($sformatf("vec%0d_start", idx), {63'd0, unit_start}, {63'd0, v.start});
        chk($sformatf("vec%0d_div", idx), {63'd0, unit_div}, {63'd0, v.dv});
        chk($sformatf("vec%0d_signed", idx), {63'd0, unit_signed}, {63'd0, v.sgn});
        chk($sformatf("vec%0d_ab", idx), {unit_a, unit_b}, {v.rs, v.rt});
        k = 0;
        while (!hilo_we && k < 80) begin
            next();
            @(negedge clk);
            k++;
        end
        chk($sformatf("vec%0d_latency", idx), 64'(k), 64'(v.lat));
        chk($sformatf("vec%0d_wdata", idx), hilo_wdata, v.wd);
        chk($sformatf("vec%0d_div_zero", idx), {63'd0, div_zero}, {63'd0, v.dz});
        next();
        @(negedge clk);
        chk($sformatf("vec%0d_we_once", idx), {62'd0, hilo_we, busy}, 64'd0);
    endtask

    // Cancel a DIV at RUN cnt=10 by flush or by reset
    task automatic cancel_seq(input bit use_reset);
        bit we_seen;
        next();
        ex_valid = 1'b1; ex_op = 3'd3; ex_rs = 32'd1000; ex_rt = 32'd3;
        next();
        ex_valid = 1'b0; ex_op = 3'd0;
        repeat (21) next();
        if (use_reset) reset = 1'b1;
        else           flush = 1'b1;
        @(negedge clk);
        chk("cancel_busy_before", {63'd0, busy}, 64'd1);
        next();
        reset = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("cancel_abort", {63'd0, unit_abort}, {63'd0, !use_reset});
        chk("cancel_busy_we", {62'd0, busy, hilo_we}, 64'd0);
        next();
        @(negedge clk);
        chk("cancel_abort_len", {63'd0, unit_abort}, 64'd0);
        we_seen = 1'b0;
        repeat (40) begin
            next();
            @(negedge clk);
            if (hilo_we) we_seen = 1'b1;
        end
        chk("cancel_no_write", {63'd0, we_seen}, 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        vecs[0] = '{3'd4, 32'd100, 32'd7, 64'h0, 64'h0000000E_00000002, DIV_LAT, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0000000E_00000002};
        vecs[1] = '{3'd1, 32'hFFFFFFFD, 32'd5, 64'h0, 64'hFFFFFFF1_FFFFFFFF, MUL_LAT, 1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFFFFF1_FFFFFFFF};
        vecs[2] = '{3'd2, 32'h00010000, 32'h00010000, 64'h0, 64'h00000000_00000001, MUL_LAT, 1'b1, 1'b0, 1'b0, 1'b0, 64'h00000000_00000001};
        vecs[3] = '{3'd3, 32'd55, 32'd0, 64'h0, 64'hA5A5A5A5_5A5A5A5A, DIV_LAT, 1'b1, 1'b1, 1'b1, 1'b1, 64'hA5A5A5A5_5A5A5A5A};
        vecs[4] = '{3'd4, 32'd9, 32'd0, 64'h0, 64'h12345678_9ABCDEF0, DIV_LAT, 1'b1, 1'b1, 1'b0, 1'b1, 64'h12345678_9ABCDEF0};
        vecs[5] = '{3'd6, 32'hDEADBEEF, 32'd1, 64'h11112222_33334444, 64'hFFFF, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hDEADBEEF_33334444};
        vecs[6] = '{3'd5, 32'hCAFEF00D, 32'd0, 64'h11112222_33334444, 64'hFFFF, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h11112222_CAFEF00D};
        vecs[7] = '{3'd1, 32'd5, 32'd0, 64'h0, 64'h0, MUL_LAT, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};

        // reset state, with busy-sensitive inputs active
        hilo_cur = 64'hFFFF_0000_FFFF_0000; unit_result = 64'h1234_5678_9ABC_DEF0; mf_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_ab", {unit_a, unit_b}, 64'd0);
        chk("reset_wdata", hilo_wdata, 64'd0);
        chk("reset_flags", {55'd0, unit_start, unit_div, unit_signed, unit_abort, busy, stall, hilo_we, div_zero}, 64'd0);
        mf_req = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i);

        // MULT, then MFHI/MFLO in ID while it runs: stalled through WRITE
        next();
        ex_valid = 1'b1; ex_op = 3'd1; ex_rs = 32'd6; ex_rt = 32'd7;
        next();
        ex_valid = 1'b0; ex_op = 3'd0; mf_req = 1'b1;
        for (int k = 0; k <= MUL_LAT; k++) begin
            @(negedge clk);
            chk($sformatf("mf_stall_k%0d", k), {63'd0, stall}, 64'd1);
            next();
        end
        @(negedge clk);
        chk("mf_stall_released", {62'd0, stall, busy}, 64'd0);
        next();
        mf_req = 1'b0;

        // DIV by zero followed by a DIVU held in EX by stall
        ex_valid = 1'b1; ex_op = 3'd3; ex_rs = 32'd77; ex_rt = 32'd0;
        next();
        ex_op = 3'd4; ex_rs = 32'd50; ex_rt = 32'd5;
        for (int k = 0; k <= DIV_LAT; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_stall_k%0d", k), {63'd0, stall}, 64'd1);
            if (k == DIV_LAT) chk("b2b_we_dz", {62'd0, hilo_we, div_zero}, 64'd3);
            next();
        end
        @(negedge clk);
        chk("b2b_idle_gap", {62'd0, stall, busy}, 64'd0);
        next();
        ex_valid = 1'b0; ex_op = 3'd0;
        @(negedge clk);
        chk("b2b_second_start", {61'd0, unit_start, unit_div, unit_signed}, 64'd6);
        chk("b2b_second_b", {32'd0, unit_b}, 64'd5);
        wait_idle();

        // cancel by flush, then by reset
        cancel_seq(1'b0);
        cancel_seq(1'b1);

        // MULTU with flush on the accept edge is dropped
        next();
        ex_valid = 1'b1; ex_op = 3'd2; ex_rs = 32'h1234; ex_rt = 32'd3; flush = 1'b1;
        next();
        ex_valid = 1'b0; ex_op = 3'd0; flush = 1'b0;
        @(negedge clk);
        chk("flush_accept_dropped", {62'd0, unit_start, busy}, 64'd0);

        // MF in ID while the op is being accepted from IDLE: no stall
        next();
        ex_valid = 1'b1; ex_op = 3'd2; ex_rs = 32'd4; ex_rt = 32'd4; mf_req = 1'b1;
        @(negedge clk);
        chk("mf_accept_same_cycle", {63'd0, stall}, 64'd0);
        next();
        ex_valid = 1'b0; ex_op = 3'd0; mf_req = 1'b0;
        wait_idle();

        // randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            next();
            reset       = ($urandom_range(0, 199) == 0);
            ex_valid    = $urandom_range(0, 1);
            ex_op       = 3'($urandom_range(0, 7));
            ex_rs       = $urandom;
            ex_rt       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            mf_req      = ($urandom_range(0, 9) < 3);
            flush       = ($urandom_range(0, 24) == 0);
            hilo_cur    = {$urandom, $urandom};
            unit_result = {$urandom, $urandom};
        end
        next();
        reset = 1'b0; ex_valid = 1'b0; ex_op = 3'd0; mf_req = 1'b0; flush = 1'b0;
        wait_idle();
        next();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
